sam_seq: RTL and testbench

- Sequencer for the square-and-multiply (sam_o) modular-exponentiation core array.
- Accepts a start request and exponent, then steps exponent bits MSB-first, one bit per step.
- For each step it drives the core's bit input, its seed-select and its register enable, plus a write strobe and address for the per-step trace RAM (ram64).
- Can repeat the same exponentiation RUNS times back-to-back for trace collection; sits between the experiment top level and the sam_o/ram64 instances.

---
 rtl/sam_seq.sv | 128 ++++++++++++
 tb/tb_sam_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sam_seq.sv
// sam_seq: steps a latched exponent MSB-first through the square-and-multiply core and trace RAM.
// Define SAM_SEQ_TRIGGER_EN to add scope_trig, a one-cycle trigger at the start of each run.
module sam_seq #(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned STEP_CYC = 1,
  parameter int unsigned RUNS     = 4,
  localparam int unsigned BW      = (EXP_W > 1) ? $clog2(EXP_W) : 1,
  localparam int unsigned RW      = $clog2(RUNS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              busy,
  output logic              done,
  output logic              e_bit,
  output logic              z_init,
  output logic              step_en,
  output logic              trace_we,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [BW-1:0]     bit_idx,
`ifdef SAM_SEQ_TRIGGER_EN
  output logic              scope_trig,
`endif
  output logic [RW-1:0]     run_idx
);

  localparam int unsigned WW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(EXP_W - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(RUNS - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(STEP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [RW-1:0]       run_q, run_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic                in_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      bit_q   <= '0;
      run_q   <= '0;
      addr_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      bit_q   <= bit_d;
      run_q   <= run_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    bit_d   = bit_q;
    run_d   = run_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          exp_d   = exp_in;
          bit_d   = BIT_LAST;
          run_d   = '0;
          addr_d  = '0;
          wait_d  = WAIT_LOAD;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        // abort wins over step completion, so the address of the interrupted step is kept
        if (abort) begin
          state_d = S_IDLE;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WW'(1);
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          wait_d = WAIT_LOAD;
          if (bit_q != '0) begin
            bit_d = bit_q - BW'(1);
          end else if (run_q != RUN_LAST) begin
            bit_d = BIT_LAST;
            run_d = run_q + RW'(1);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_step    = (state_q == S_STEP);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign e_bit      = in_step & exp_q[bit_q];
  assign z_init     = in_step && (bit_q == BIT_LAST);
  assign step_en    = in_step && (wait_q == '0);
  assign trace_we   = step_en;
  assign trace_addr = addr_q;
  assign bit_idx    = bit_q;
  assign run_idx    = run_q;

`ifdef SAM_SEQ_TRIGGER_EN
  assign scope_trig = in_step && (bit_q == BIT_LAST) && (wait_q == WAIT_LOAD);
`endif

endmodule

// File: tb/tb_sam_seq.sv
// Directed bench for sam_seq: four parameterisations sharing clock, reset, abort and exponent.
module tb_sam_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, abort;
  logic [7:0] exp_in;
  logic       start_a, start_b, start_c, start_d;

  logic       busy_a, done_a, e_bit_a, z_init_a, step_en_a, trace_we_a, run_idx_a, trig_a;
  logic [4:0] trace_addr_a;
  logic [2:0] bit_idx_a;
  logic       busy_b, done_b, e_bit_b, z_init_b, step_en_b, trace_we_b, run_idx_b, trig_b;
  logic [4:0] trace_addr_b;
  logic [2:0] bit_idx_b;
  logic       busy_c, done_c, e_bit_c, z_init_c, step_en_c, trace_we_c, trig_c;
  logic [4:0] trace_addr_c;
  logic [2:0] bit_idx_c, run_idx_c;
  logic       busy_d, done_d, e_bit_d, z_init_d, step_en_d, trace_we_d, trig_d;
  logic [2:0] trace_addr_d, bit_idx_d;
  logic [1:0] run_idx_d;

  int pass_cnt = 0;
  int total_cnt = 0;

  sam_seq #(.EXP_W(8), .ADDR_W(5), .STEP_CYC(1), .RUNS(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .exp_in(exp_in),
    .busy(busy_a), .done(done_a), .e_bit(e_bit_a), .z_init(z_init_a),
    .step_en(step_en_a), .trace_we(trace_we_a), .trace_addr(trace_addr_a),
    .bit_idx(bit_idx_a),
`ifdef SAM_SEQ_TRIGGER_EN
    .scope_trig(trig_a),
`endif
    .run_idx(run_idx_a));

  sam_seq #(.EXP_W(8), .ADDR_W(5), .STEP_CYC(3), .RUNS(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .exp_in(exp_in),
    .busy(busy_b), .done(done_b), .e_bit(e_bit_b), .z_init(z_init_b),
    .step_en(step_en_b), .trace_we(trace_we_b), .trace_addr(trace_addr_b),
    .bit_idx(bit_idx_b),
`ifdef SAM_SEQ_TRIGGER_EN
    .scope_trig(trig_b),
`endif
    .run_idx(run_idx_b));

  sam_seq #(.EXP_W(8), .ADDR_W(5), .STEP_CYC(1), .RUNS(4)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort), .exp_in(exp_in),
    .busy(busy_c), .done(done_c), .e_bit(e_bit_c), .z_init(z_init_c),
    .step_en(step_en_c), .trace_we(trace_we_c), .trace_addr(trace_addr_c),
    .bit_idx(bit_idx_c),
`ifdef SAM_SEQ_TRIGGER_EN
    .scope_trig(trig_c),
`endif
    .run_idx(run_idx_c));

  sam_seq #(.EXP_W(8), .ADDR_W(3), .STEP_CYC(1), .RUNS(2)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .abort(abort), .exp_in(exp_in),
    .busy(busy_d), .done(done_d), .e_bit(e_bit_d), .z_init(z_init_d),
    .step_en(step_en_d), .trace_we(trace_we_d), .trace_addr(trace_addr_d),
    .bit_idx(bit_idx_d),
`ifdef SAM_SEQ_TRIGGER_EN
    .scope_trig(trig_d),
`endif
    .run_idx(run_idx_d));

`ifndef SAM_SEQ_TRIGGER_EN
  assign trig_a = 1'b0;
  assign trig_b = 1'b0;
  assign trig_c = 1'b0;
  assign trig_d = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done on the selected instance, then steps into IDLE.
  task automatic drain(input int sel);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      case (sel)
        0: seen = done_a;
        1: seen = done_b;
        2: seen = done_c;
        default: seen = done_d;
      endcase
      if (!seen) tick();
    end
    total_cnt++;
    if (seen !== 1'b1) $display("FAIL drain_%0d: done got %b want 1", sel, seen);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b0; abort = 1'b0; exp_in = 8'h00;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    tick(); tick();
    got = {busy_a, done_a, e_bit_a, z_init_a, step_en_a, trace_we_a};
    total_cnt++;
    if (got !== 6'b0 || trace_addr_a !== 5'd0 || bit_idx_a !== 3'd0 || run_idx_a !== 1'b0)
      $display("FAIL reset_a: got %b addr %0d bit %0d run %0d want all 0", got, trace_addr_a, bit_idx_a, run_idx_a);
    else pass_cnt++;
    got = {busy_c, done_c, e_bit_c, z_init_c, step_en_c, trace_we_c};
    total_cnt++;
    if (got !== 6'b0 || trace_addr_c !== 5'd0 || run_idx_c !== 3'd0 || trig_c !== 1'b0)
      $display("FAIL reset_c: got %b addr %0d run %0d trig %b want all 0", got, trace_addr_c, run_idx_c, trig_c);
    else pass_cnt++;
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] ev;
    logic [5:0] got, want;
    ev = 8'b01110001;
    exp_in = ev; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got  = {busy_a, done_a, e_bit_a, z_init_a, step_en_a, trace_we_a};
      want = {1'b1, 1'b0, ev[7-i], (i == 0), 1'b1, 1'b1};
      total_cnt++;
      if (got !== want || trace_addr_a !== 5'(i) || bit_idx_a !== 3'(7 - i))
        $display("FAIL basic_step%0d: got %b addr %0d bit %0d want %b addr %0d bit %0d",
                 i, got, trace_addr_a, bit_idx_a, want, i, 7 - i);
      else pass_cnt++;
      tick();
    end
    got = {busy_a, done_a, e_bit_a, z_init_a, step_en_a, trace_we_a};
    total_cnt++;
    if (got !== 6'b110000) $display("FAIL basic_done: got %b want 110000", got);
    else pass_cnt++;
    tick();
    got = {busy_a, done_a, e_bit_a, z_init_a, step_en_a, trace_we_a};
    total_cnt++;
    if (got !== 6'b000000) $display("FAIL basic_idle: got %b want 000000", got);
    else pass_cnt++;
  endtask

  task automatic test_step_cyc();
    logic [7:0] ev;
    logic [3:0] got, want;
    int pulses;
    ev = 8'b01110001;
    pulses = 0;
    exp_in = ev; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      got  = {busy_b, step_en_b, trace_we_b, e_bit_b};
      want = {1'b1, (c % 3 == 0), (c % 3 == 0), ev[7 - (c - 1) / 3]};
      total_cnt++;
      if (got !== want) $display("FAIL stepcyc_c%0d: got %b want %b", c, got, want);
      else pass_cnt++;
      if (step_en_b) pulses++;
      tick();
    end
    total_cnt++;
    if (done_b !== 1'b1 || busy_b !== 1'b1 || pulses != 8)
      $display("FAIL stepcyc_done: done %b busy %b pulses %0d want 1 1 8", done_b, busy_b, pulses);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy_b !== 1'b0 || done_b !== 1'b0) $display("FAIL stepcyc_idle: busy %b done %b want 0 0", busy_b, done_b);
    else pass_cnt++;
  endtask

  task automatic test_runs();
    logic [7:0] ev;
    logic [4:0] got, want;
    ev = 8'b10100110;
    exp_in = ev; start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int i = 0; i < 32; i++) begin
      got  = {busy_c, step_en_c, trace_we_c, z_init_c, e_bit_c};
      want = {1'b1, 1'b1, 1'b1, (i % 8 == 0), ev[7 - (i % 8)]};
      total_cnt++;
      if (got !== want || run_idx_c !== 3'(i / 8) || trace_addr_c !== 5'(i))
        $display("FAIL runs_step%0d: got %b run %0d addr %0d want %b run %0d addr %0d",
                 i, got, run_idx_c, trace_addr_c, want, i / 8, i);
      else pass_cnt++;
`ifdef SAM_SEQ_TRIGGER_EN
      total_cnt++;
      if (trig_c !== (i % 8 == 0)) $display("FAIL runs_trig%0d: got %b want %b", i, trig_c, (i % 8 == 0));
      else pass_cnt++;
`endif
      tick();
    end
    total_cnt++;
    if (done_c !== 1'b1 || run_idx_c !== 3'd3 || bit_idx_c !== 3'd0 || step_en_c !== 1'b0)
      $display("FAIL runs_done: done %b run %0d bit %0d en %b want 1 3 0 0", done_c, run_idx_c, bit_idx_c, step_en_c);
    else pass_cnt++;
    tick();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    total_cnt++;
    if (trace_addr_c !== 5'd0 || run_idx_c !== 3'd0 || bit_idx_c !== 3'd7 || z_init_c !== 1'b1)
      $display("FAIL runs_restart: addr %0d run %0d bit %0d z %b want 0 0 7 1", trace_addr_c, run_idx_c, bit_idx_c, z_init_c);
    else pass_cnt++;
    drain(2);
  endtask

  task automatic test_addr_wrap();
    exp_in = 8'hA5; start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (trace_addr_d !== 3'(i % 8) || step_en_d !== 1'b1 || run_idx_d !== 2'(i / 8))
        $display("FAIL wrap_step%0d: addr %0d en %b run %0d want %0d 1 %0d", i, trace_addr_d, step_en_d, run_idx_d, i % 8, i / 8);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (done_d !== 1'b1) $display("FAIL wrap_done: done %b want 1", done_d);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_start_held();
    logic [7:0] ev, ev2;
    ev = 8'b01110001; ev2 = 8'b10001110;
    exp_in = ev; start_a = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) exp_in = ev2;
      total_cnt++;
      if (e_bit_a !== ev[7-i] || step_en_a !== 1'b1)
        $display("FAIL held_step%0d: e_bit %b en %b want %b 1", i, e_bit_a, step_en_a, ev[7-i]);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (done_a !== 1'b1) $display("FAIL held_done: done %b want 1", done_a);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy_a !== 1'b0 || step_en_a !== 1'b0) $display("FAIL held_idle: busy %b en %b want 0 0", busy_a, step_en_a);
    else pass_cnt++;
    tick();
    start_a = 1'b0;
    total_cnt++;
    if (busy_a !== 1'b1 || z_init_a !== 1'b1 || e_bit_a !== ev2[7] || bit_idx_a !== 3'd7)
      $display("FAIL held_rerun: busy %b z %b e_bit %b bit %0d want 1 1 %b 7", busy_a, z_init_a, e_bit_a, bit_idx_a, ev2[7]);
    else pass_cnt++;
    drain(0);
  endtask

  task automatic test_abort();
    logic [5:0] got;
    logic       stray;
    exp_in = 8'b01110001; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick(); tick();
    total_cnt++;
    if (trace_addr_a !== 5'd4 || bit_idx_a !== 3'd3 || step_en_a !== 1'b1)
      $display("FAIL abort_pre: addr %0d bit %0d en %b want 4 3 1", trace_addr_a, bit_idx_a, step_en_a);
    else pass_cnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    got = {busy_a, done_a, e_bit_a, z_init_a, step_en_a, trace_we_a};
    total_cnt++;
    if (got !== 6'b0 || trace_addr_a !== 5'd4)
      $display("FAIL abort_idle: got %b addr %0d want 000000 addr 4", got, trace_addr_a);
    else pass_cnt++;
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stray |= step_en_a | trace_we_a | done_a | busy_a;
      tick();
    end
    total_cnt++;
    if (stray !== 1'b0) $display("FAIL abort_quiet: activity %b want 0", stray);
    else pass_cnt++;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    total_cnt++;
    if (bit_idx_a !== 3'd7 || trace_addr_a !== 5'd0 || z_init_a !== 1'b1 || e_bit_a !== 1'b0)
      $display("FAIL abort_restart: bit %0d addr %0d z %b e %b want 7 0 1 0", bit_idx_a, trace_addr_a, z_init_a, e_bit_a);
    else pass_cnt++;
    drain(0);
  endtask

  task automatic test_reset_mid();
    logic [5:0] got;
    logic       stray;
    exp_in = 8'b01110001; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b0;
    #1;
    got = {busy_a, done_a, e_bit_a, z_init_a, step_en_a, trace_we_a};
    total_cnt++;
    if (got !== 6'b0 || trace_addr_a !== 5'd0 || bit_idx_a !== 3'd0)
      $display("FAIL rstmid_clear: got %b addr %0d bit %0d want 000000 0 0", got, trace_addr_a, bit_idx_a);
    else pass_cnt++;
    @(negedge clk) rst = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      stray |= step_en_a | trace_we_a | done_a | busy_a;
    end
    total_cnt++;
    if (stray !== 1'b0) $display("FAIL rstmid_quiet: activity %b want 0", stray);
    else pass_cnt++;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    total_cnt++;
    if (bit_idx_a !== 3'd7 || step_en_a !== 1'b1 || trace_addr_a !== 5'd0 || e_bit_a !== 1'b0)
      $display("FAIL rstmid_restart: bit %0d en %b addr %0d e %b want 7 1 0 0", bit_idx_a, step_en_a, trace_addr_a, e_bit_a);
    else pass_cnt++;
    drain(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_step_cyc();
    test_runs();
    test_addr_wrap();
    test_start_held();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
